core_dmem_resp: RTL and testbench
=================================

Name: core_dmem_resp

Overview:
- Data-memory responder: the target end of the LSU load/store request interface driven from the EX stage.
- Accepts one request at a time over a valid/ready handshake.
- Performs byte-masked writes or full-word reads on an internal single-port array.
- Returns a response after a fixed, parameterized latency, then holds it until the LSU accepts it. Used as the simulation and FPGA data memory in place of the DPI-C model.

Parameters:
- ADDR_WIDTH, 32, byte address width of req_addr
- DATA_WIDTH, 64, data word width; must equal CORE_XLEN
- DEPTH_LOG2, 10, log2 of the number of DATA_WIDTH words in the array
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- LATENCY, 2, cycles from the request-accept edge to rsp_valid high; legal range 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address; bits [2:0] are ignored (lane selection is done by req_wmask)
- req_wdata  in  DATA_WIDTH  store data, lane-aligned
- req_wmask  in  DATA_WIDTH/8  byte-lane write enables; used only when req_wen=1
- rsp_valid  out  1  response present
- rsp_ready  in  1  LSU accepts the response
- rsp_rdata  out  DATA_WIDTH  full read word; 0 for stores and for errors
- rsp_err  out  1  address was outside [BASE_ADDR, BASE_ADDR + 8*2^DEPTH_LOG2)

Behaviour:
- Single clock, clk. rst_n is asynchronous and active-low. Array contents are not reset.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0.
- Accept condition: acc = req_valid & req_ready.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). This allows back-to-back transactions with zero bubble on the request side.
- Address decode: off = req_addr - BASE_ADDR (ADDR_WIDTH wrap-around arithmetic); in_range = (off >> (DEPTH_LOG2+3)) == 0; word index = off[DEPTH_LOG2+2:3].
- On acc:
  - Store, in range: each lane i with req_wmask[i]=1 gets req_wdata[8i+7:8i] written at that edge; other lanes are unchanged.
  - Load, in range: the word is read combinationally from the array (pre-write value irrelevant, since loads never write) and registered into the rdata holding register.
  - Out of range: no write; holding rdata=0, err=1.
  - Store: holding rdata=0, err=0.
- State machine:
  - IDLE: on acc, if LATENCY==1 go to RESP; else go to WAIT with cnt=LATENCY-2.
  - WAIT: if cnt==0 go to RESP, else cnt-1. No acceptance in WAIT (req_ready=0).
  - RESP: rsp_valid=1 and rsp_rdata/rsp_err driven from the holding registers, held stable until rsp_ready.
    - rsp_ready & ~req_valid: go to IDLE.
    - rsp_ready & req_valid: accept the new request in the same cycle and transition as from IDLE.
- Latency: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Ordering: a load following a store to the same word observes the store, because the write completes at the store's accept edge.
- rsp_rdata and rsp_err are don't-care when rsp_valid=0, but the implementation holds the last values.
- Reset asserted mid-transaction: the in-flight response is dropped, the FSM returns to IDLE, and any write already committed remains.
- wmask=0 store: legal; no lanes change and a response is still returned.

Decomposition:
- Shared package/defines in core_defines.v:
  - DMEM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - default BASE_ADDR
  - DMEM_LAT_W=4
- Sub-module core_dmem_sram: a single-port, byte-masked, DEPTH x DATA_WIDTH array with combinational read and synchronous write (ports: clk, addr, wen, wmask, wdata, rdata). The top holds the FSM, counter, decode and response registers, built on gnrl_dffr/gnrl_dfflr.

Test Plan:
- After reset, store 0x1122334455667788 to 0x80000008 with wmask=0xFF, then load 0x80000008 (LATENCY=2) -> store rsp_valid 2 cycles after accept with rdata=0 and err=0; load rsp_rdata=0x1122334455667788.
- Partial store of 0xAAAA_0000_0000_0000 to 0x80000008 with wmask=0xC0, then load -> rdata=0xAAAA334455667788.
- Load from 0x7FFFFFF8 and from BASE+0x2000 (DEPTH_LOG2=10) -> rsp_err=1, rdata=0; array unchanged, checked by a later load of 0x80000000.
- Back-pressure: hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid and rsp_rdata stable, req_ready=0. Raise rsp_ready -> the new request is accepted that same cycle and its response arrives LATENCY cycles later.
- LATENCY=1 streaming with rsp_ready=1 and 4 loads back-to-back -> one response per cycle, in order, no bubbles.
- Assert rst_n low while in WAIT -> rsp_valid=0 and req_ready=1 immediately, with no response after release. A store issued before the reset is still readable.

Source files
------------

// File: rtl/core_dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_dmem_resp_pkg
// Brief   : Shared state encoding and constants for the data-memory responder.
// Revision: 1.0
// ============================================================================
package core_dmem_resp_pkg;

    localparam int          DMEM_LAT_W     = 4;
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // WAIT is skipped entirely when the latency is a single cycle.
    function automatic logic [DMEM_LAT_W-1:0] dmem_cnt_init(input int lat);
        return (lat > 1) ? DMEM_LAT_W'(lat - 2) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_dmem_resp_sram.sv
`default_nettype none
// ============================================================================
// Module  : core_dmem_resp_sram
// Brief   : Single-port byte-masked array, combinational read, synchronous write.
// Revision: 1.0
// ============================================================================
module core_dmem_resp_sram #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic                    wen,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule
`default_nettype wire

// File: rtl/core_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module  : core_dmem_resp
// Brief   : LSU-facing data memory with fixed response latency and hold-until-ack.
// Revision: 1.0
// ============================================================================
module core_dmem_resp
    import core_dmem_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DMEM_BASE_ADDR),
    parameter int                    LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam logic [DMEM_LAT_W-1:0] CNT_INIT = dmem_cnt_init(LATENCY);

    dmem_state_e           state_q;
    logic [DMEM_LAT_W-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_acc;
    logic [DATA_WIDTH-1:0] w_sram_rdata;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  err_d;

    // Wrap-around subtraction makes addresses below the base land far out of range.
    assign w_off      = req_addr - BASE_ADDR;
    assign w_in_range = ((w_off >> (DEPTH_LOG2 + 3)) == '0);
    assign w_idx      = w_off[DEPTH_LOG2+2:3];

    assign req_ready = (state_q == DMEM_IDLE) | ((state_q == DMEM_RESP) & rsp_ready);
    assign w_acc     = req_valid & req_ready;

    assign rdata_d = (w_in_range & ~req_wen) ? w_sram_rdata : '0;
    assign err_d   = ~w_in_range;

    core_dmem_resp_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk   (clk),
        .addr  (w_idx),
        .wen   (w_acc & req_wen & w_in_range),
        .wmask (req_wmask),
        .wdata (req_wdata),
        .rdata (w_sram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                DMEM_IDLE: ;
                DMEM_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= DMEM_RESP;
                    end else begin
                        cnt_q <= cnt_q - DMEM_LAT_W'(1);
                    end
                end
                DMEM_RESP: begin
                    if (rsp_ready && !req_valid) begin
                        state_q <= DMEM_IDLE;
                    end
                end
                default: state_q <= DMEM_IDLE;
            endcase
            // A new accept overrides the above, including the RESP->RESP/WAIT chain.
            if (w_acc) begin
                state_q <= (LATENCY == 1) ? DMEM_RESP : DMEM_WAIT;
                cnt_q   <= CNT_INIT;
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    assign rsp_valid = (state_q == DMEM_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_dmem_resp
// Brief   : Scoreboard bench for core_dmem_resp (LATENCY=2 main, LATENCY=1 stream).
// Revision: 1.0
// ============================================================================
module tb_core_dmem_resp;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          LAT  = 2;

    typedef struct {
        logic [63:0] d;
        logic        e;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    logic        b_valid = 1'b0;
    logic        b_ready;
    logic        b_wen = 1'b0;
    logic [31:0] b_addr = '0;
    logic [63:0] b_wdata = '0;
    logic [7:0]  b_wmask = 8'hFF;
    logic        b_rsp_valid;
    logic        b_rsp_ready = 1'b1;
    logic [63:0] b_rdata;
    logic        b_err;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    exp_t        q[$];
    logic [63:0] mem_m [int];

    core_dmem_resp #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    core_dmem_resp #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_wen(b_wen),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_wmask(b_wmask),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rdata), .rsp_err(b_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: memory as an associative array of words, commit at accept.
    function automatic exp_t model(input logic wen, input logic [31:0] addr,
                                   input logic [63:0] wd, input logic [7:0] wm, input int due);
        exp_t        r;
        logic [31:0] off;
        int          idx;
        logic [63:0] cur;
        off   = addr - BASE;
        idx   = int'(off >> 3);
        r.due = due;
        if (off >= 32'h2000) begin
            r.d = '0; r.e = 1'b1;
        end else if (wen) begin
            cur = mem_m.exists(idx) ? mem_m[idx] : 64'h0;
            for (int b = 0; b < 8; b++)
                if (wm[b]) cur[8*b +: 8] = wd[8*b +: 8];
            mem_m[idx] = cur;
            r.d = '0; r.e = 1'b0;
        end else begin
            r.d = mem_m[idx]; r.e = 1'b0;
        end
        return r;
    endfunction

    // Monitor / scoreboard for the main instance.
    always @(negedge clk) begin
        logic ev, er;
        if (!rst_n) begin
            q.delete();
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].due);
            er = (q.size() == 0) || (ev && rsp_ready);
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            chk("req_ready", 64'(req_ready), 64'(er));
            if (ev && rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, q[0].d);
                chk("rsp_err", 64'(rsp_err), 64'(q[0].e));
                if (rsp_ready) void'(q.pop_front());
            end
            if (req_valid && req_ready)
                q.push_back(model(req_wen, req_addr, req_wdata, req_wmask, cyc + LAT));
        end
    end

    task automatic issue(input logic wen, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [7:0] wm);
        int t;
        t = 0;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wmask = wm;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 200);
        if (!req_ready) begin
            n_chk++; n_fail++;
            $display("FAIL issue_timeout: req_ready %b expected 1 within 200 cycles", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d responses pending expected 0", q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] ref1 [4];
        logic [31:0] a;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", rsp_rdata, 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++) issue(1'b1, BASE + 32'(8*w), 64'h0, 8'hFF);
        issue(1'b1, BASE + 32'h1FF8, 64'h0, 8'hFF);
        drain();

        issue(1'b1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
        issue(1'b0, 32'h8000_0008, 64'h0, 8'h00);
        issue(1'b1, 32'h8000_0008, 64'hAAAA_0000_0000_0000, 8'hC0);
        issue(1'b0, 32'h8000_0008, 64'h0, 8'h00);
        issue(1'b1, 32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        issue(1'b0, 32'h8000_0008, 64'h0, 8'h00);
        issue(1'b1, 32'h7FFF_FFF8, 64'h5555_5555_5555_5555, 8'hFF);
        issue(1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00);
        issue(1'b0, BASE + 32'h2000, 64'h0, 8'h00);
        issue(1'b0, 32'h8000_0000, 64'h0, 8'h00);
        issue(1'b0, BASE + 32'h1FFF, 64'h0, 8'h00);
        drain();

        // Back-pressure: response held while a new request waits.
        rdy_mode = 1;
        @(posedge clk); #1;
        issue(1'b0, 32'h8000_0008, 64'h0, 8'h00);
        fork
            issue(1'b0, 32'h8000_0000, 64'h0, 8'h00);
            begin
                repeat (LAT + 5) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Reset while a load sits in WAIT; the earlier store must survive.
        issue(1'b1, BASE + 32'h10, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        drain();
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(1'b0, BASE + 32'h10, 64'h0, 8'h00);
        drain();

        rdy_mode = 2;
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 6)      a = BASE + 32'(8 * $urandom_range(0, 15));
            else if (r == 7) a = BASE + 32'h1FF8;
            else if (r == 8) a = BASE - 32'(8 * $urandom_range(1, 4));
            else             a = BASE + 32'h2000 + 32'(8 * $urandom_range(0, 3));
            a = a | 32'($urandom_range(0, 7));
            issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        rdy_mode = 0;
        drain();

        // LATENCY=1 instance: back-to-back streaming, one response per cycle.
        for (int i = 0; i < 4; i++) ref1[i] = {$urandom, $urandom};
        b_valid = 1'b1; b_wen = 1'b1; b_wmask = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            b_addr = BASE + 32'(8*i); b_wdata = ref1[i];
            @(posedge clk); #1;
            chk("l1_store_valid", 64'(b_rsp_valid), 64'd1);
            chk("l1_store_rdata", b_rdata, 64'd0);
        end
        b_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_addr = BASE + 32'(8*i);
            @(posedge clk); #1;
            chk("l1_load_valid", 64'(b_rsp_valid), 64'd1);
            chk("l1_load_rdata", b_rdata, ref1[i]);
            chk("l1_load_err", 64'(b_err), 64'd0);
            chk("l1_req_ready", 64'(b_ready), 64'd1);
        end
        b_valid = 1'b0;
        @(posedge clk); #1;
        chk("l1_idle_valid", 64'(b_rsp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
